// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter.
// FSM encodings and frame geometry live here.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS  = 8;
    // start + 8 data + stop; parity adds one more when enabled
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Byte-in handshake plus serial-line status bundle.
// master drives bytes in, slave is the transmitter.
interface serial_frame_tx_if;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       txd;
    logic       busy;
    logic       done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  txd,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output txd,
        output busy,
        output done
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Cycles-per-bit counter: tick marks the last cycle of a bit.
// clear holds the count at zero so the first bit starts aligned.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, 8 data, optional parity, stop.
// All line outputs are registered from the next-state logic.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int MSB_FIRST    = 0
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_tx_if.slave   bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state, state_n;
    logic [7:0] sr, sr_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic       par, par_n;
    logic       txd_q, txd_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       tick;
    logic       xfer;
    logic [7:0] sr_sh;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state == IDLE),
        .tick (tick)
    );

    assign bus.din_ready = (state == IDLE);
    assign bus.txd       = txd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    assign xfer  = bus.din_valid && (state == IDLE);
    assign sr_sh = (MSB_FIRST != 0) ? {sr[6:0], 1'b0}
                                    : {1'b0, sr[7:1]};

    function automatic logic head(input logic [7:0] b);
        return (MSB_FIRST != 0) ? b[7] : b[0];
    endfunction

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bitcnt_n = bitcnt;
        par_n    = par;
        txd_n    = txd_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_n  = START;
                    sr_n     = bus.din;
                    par_n    = (^bus.din) ^ (PARITY_ODD != 0);
                    bitcnt_n = '0;
                    txd_n    = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    txd_n   = head(sr);
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitcnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            txd_n   = par;
                        end else begin
                            state_n = STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        sr_n     = sr_sh;
                        bitcnt_n = bitcnt + 3'd1;
                        txd_n    = head(sr_sh);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    txd_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            bitcnt <= '0;
            par    <= 1'b0;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            bitcnt <= bitcnt_n;
            par    <= par_n;
            txd_q  <= txd_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx across five configurations.
// Driver pushes hand-computed frames; per-DUT monitors decode txd.
module tb_serial_frame_tx;

    localparam int ND = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [7:0] din_a  [ND];
    logic       vld_a  [ND];
    logic       rdy_a  [ND];
    logic       txd_a  [ND];
    logic       busy_a [ND];
    logic       done_a [ND];

    typedef struct {
        int          dut;
        logic [10:0] bits;
        bit          abort;
        bit          b2b;
    } frame_t;

    frame_t q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done [ND];
    int done_cnt [ND];
    int exp_done [ND];

    // dut0 default, 1 even parity, 2 odd parity, 3 msb first, 4 one clk/bit
    function automatic int cpb(input int i);
        return (i == 4) ? 1 : 4;
    endfunction

    function automatic int pen(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : u
        serial_frame_tx_if bus();

        assign bus.din       = din_a[g];
        assign bus.din_valid = vld_a[g];
        assign rdy_a[g]      = bus.din_ready;
        assign txd_a[g]      = bus.txd;
        assign busy_a[g]     = bus.busy;
        assign done_a[g]     = bus.done;

        serial_frame_tx #(
            .CLKS_PER_BIT(g == 4 ? 1 : 4),
            .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD  (g == 2 ? 1 : 0),
            .MSB_FIRST   (g == 3 ? 1 : 0)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );

        initial forever mon(g);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (done_a[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int i);
        int c;
        int nb;
        int start_cyc;
        logic [10:0] got;
        bit ab;
        bit stable;
        frame_t e;
        @(negedge clk);
        if (busy_a[i] !== 1'b1) return;
        c = cpb(i);
        nb = 10 + pen(i);
        got = '0;
        ab = 1'b0;
        stable = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < nb * c; k++) begin
            if (k > 0) @(negedge clk);
            if (busy_a[i] !== 1'b1) begin
                ab = 1'b1;
                break;
            end
            if (k % c == 0) got = {got[9:0], txd_a[i]};
            else if (txd_a[i] !== got[0]) stable = 1'b0;
        end
        if (!ab) @(negedge clk);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_frame dut%0d: got %0h expected none",
                     i, got);
            return;
        end
        e = q.pop_front();
        chk("frame_dut", i, e.dut);
        if (e.b2b) chk("b2b_gap", start_cyc - last_done[i], 1);
        if (ab) begin
            chk("abort_expected", 1, {31'd0, e.abort});
            chk("abort_txd_done", {txd_a[i], done_a[i]}, 2'b10);
        end else begin
            chk("unexpected_complete", 0, {31'd0, e.abort});
            chk($sformatf("frame_bits_dut%0d", i), got, e.bits);
            chk("bit_hold", stable, 1);
            chk("done_cycle_bdt",
                {busy_a[i], done_a[i], txd_a[i]}, 3'b011);
            last_done[i] = cyc;
        end
    endtask

    task automatic push(input int i, input logic [10:0] bits,
                        input bit ab, input bit b2b);
        frame_t e;
        e.dut = i;
        e.bits = bits;
        e.abort = ab;
        e.b2b = b2b;
        q.push_back(e);
        if (!ab) exp_done[i]++;
    endtask

    // called at a negedge; returns just after the accepting edge
    task automatic send(input int i, input logic [7:0] b);
        int n = 0;
        din_a[i] = b;
        vld_a[i] = 1'b1;
        while (rdy_a[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout dut%0d: got busy expected ready",
                     i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        @(negedge clk);
        while ((busy_a[i] !== 1'b0 || q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout dut%0d: got busy expected idle", i);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ND; i++) begin
            din_a[i] = 8'h00;
            vld_a[i] = 1'b0;
            last_done[i] = 0;
            done_cnt[i] = 0;
            exp_done[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset_state_dut%0d", i),
                {txd_a[i], busy_a[i], done_a[i], rdy_a[i]}, 4'b1001);
        end
        reset = 1'b0;
        @(negedge clk);

        push(0, 11'b0101001011, 1'b0, 1'b0);
        send(0, 8'hA5);
        vld_a[0] = 1'b0;
        wait_idle(0);

        push(0, 11'b0100010001, 1'b0, 1'b0);
        push(0, 11'b0010001001, 1'b0, 1'b1);
        send(0, 8'h11);
        din_a[0] = 8'h33;
        repeat (20) @(negedge clk);
        send(0, 8'h22);
        vld_a[0] = 1'b0;
        wait_idle(0);

        push(0, 11'b0, 1'b1, 1'b0);
        send(0, 8'hC3);
        vld_a[0] = 1'b0;
        repeat (17) @(negedge clk);
        reset = 1'b1;
        din_a[1] = 8'h99;
        vld_a[1] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vld_a[1] = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {rdy_a[0], rdy_a[1]}, 2'b11);
        push(0, 11'b0010110101, 1'b0, 1'b0);
        send(0, 8'h5A);
        vld_a[0] = 1'b0;
        wait_idle(0);

        push(1, 11'b01110000011, 1'b0, 1'b0);
        send(1, 8'h07);
        vld_a[1] = 1'b0;
        wait_idle(1);
        push(1, 11'b01111111101, 1'b0, 1'b0);
        send(1, 8'hFF);
        vld_a[1] = 1'b0;
        wait_idle(1);

        push(2, 11'b01110000001, 1'b0, 1'b0);
        send(2, 8'h07);
        vld_a[2] = 1'b0;
        wait_idle(2);

        push(3, 11'b0100000001, 1'b0, 1'b0);
        send(3, 8'h80);
        vld_a[3] = 1'b0;
        wait_idle(3);
        push(3, 11'b0000000011, 1'b0, 1'b0);
        send(3, 8'h01);
        vld_a[3] = 1'b0;
        wait_idle(3);

        push(4, 11'b0111111111, 1'b0, 1'b0);
        send(4, 8'hFF);
        vld_a[4] = 1'b0;
        wait_idle(4);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("done_pulses_dut%0d", i),
                done_cnt[i], exp_done[i]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
